// File: rtl/tqvp_bus_arbiter_if.sv
// Requester-side handshake bundle for one port of the TinyQV peripheral arbiter.
// The requester drives master; the arbiter takes the slave view.
interface tqvp_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  txn;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, txn, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, txn, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/tqvp_bus_arbiter.sv
// Round-robin arbiter sharing one TinyQV peripheral register port between two
// requesters; sequences each access and turns a stalled read into an error.
module tqvp_bus_arbiter #(
    parameter int unsigned READ_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tqvp_bus_arbiter_if.slave        m0,
    tqvp_bus_arbiter_if.slave        m1,
    output logic [5:0]               address,
    output logic [31:0]              data_in,
    output logic [1:0]               data_write_n,
    output logic [1:0]               data_read_n,
    input  logic [31:0]              data_out,
    input  logic                     data_ready,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(READ_TIMEOUT);

    state_t      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic        we_q;
    logic [1:0]  txn_q;
    logic [7:0]  cnt_q;
    logic [5:0]  address_q;
    logic [31:0] data_in_q;
    logic [1:0]  write_n_q;
    logic [1:0]  read_n_q;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        busy_q;

    logic        grant_d;
    logic        we_d;
    logic [1:0]  txn_d;
    logic [5:0]  addr_d;
    logic [31:0] wdata_d;
    logic [1:0]  ack_sel_d;
    logic [31:0] rdata_masked_d;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_d = 1'b0;
        if (m0.req && m1.req) begin
            grant_d = ~last_grant_q;
        end else if (m1.req) begin
            grant_d = 1'b1;
        end
        we_d    = grant_d ? m1.we    : m0.we;
        txn_d   = grant_d ? m1.txn   : m0.txn;
        addr_d  = grant_d ? m1.addr  : m0.addr;
        wdata_d = grant_d ? m1.wdata : m0.wdata;
    end

    // One-hot response target: the fresh grant in IDLE, the held grant afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            ack_sel_d = {grant_d, ~grant_d};
        end else begin
            ack_sel_d = {grant_q, ~grant_q};
        end
    end

    always_comb begin
        case (txn_q)
            2'b00:   rdata_masked_d = {24'h000000, data_out[7:0]};
            2'b01:   rdata_masked_d = {16'h0000, data_out[15:0]};
            default: rdata_masked_d = data_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            txn_q        <= '0;
            cnt_q        <= '0;
            address_q    <= '0;
            data_in_q    <= '0;
            write_n_q    <= '1;
            read_n_q     <= '1;
            ack_q        <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            // Response outputs are single-cycle; completions below override these.
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            case (state_q)
                IDLE: begin
                    if (m0.req || m1.req) begin
                        grant_q   <= grant_d;
                        we_q      <= we_d;
                        txn_q     <= txn_d;
                        address_q <= addr_d;
                        data_in_q <= wdata_d;
                        busy_q    <= 1'b1;
                        if (txn_d == 2'b11) begin
                            state_q <= RESP;
                            ack_q   <= ack_sel_d;
                            err_q   <= ack_sel_d;
                        end else begin
                            state_q <= ISSUE;
                            if (we_d) begin
                                write_n_q <= txn_d;
                            end else begin
                                read_n_q  <= txn_d;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        write_n_q <= '1;
                        state_q   <= RESP;
                        ack_q     <= ack_sel_d;
                    end else if (data_ready) begin
                        read_n_q  <= '1;
                        state_q   <= RESP;
                        ack_q     <= ack_sel_d;
                        rdata0_q  <= ack_sel_d[0] ? rdata_masked_d : '0;
                        rdata1_q  <= ack_sel_d[1] ? rdata_masked_d : '0;
                    end else begin
                        state_q   <= WAIT;
                        cnt_q     <= 8'd1;
                    end
                end
                WAIT: begin
                    // Late data still wins on the final permitted cycle.
                    if (data_ready) begin
                        read_n_q  <= '1;
                        state_q   <= RESP;
                        ack_q     <= ack_sel_d;
                        rdata0_q  <= ack_sel_d[0] ? rdata_masked_d : '0;
                        rdata1_q  <= ack_sel_d[1] ? rdata_masked_d : '0;
                    end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                        read_n_q  <= '1;
                        state_q   <= RESP;
                        ack_q     <= ack_sel_d;
                        err_q     <= ack_sel_d;
                    end else begin
                        cnt_q     <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign busy         = busy_q;

    assign m0.ack   = ack_q[0];
    assign m0.err   = err_q[0];
    assign m0.rdata = rdata0_q;
    assign m1.ack   = ack_q[1];
    assign m1.err   = err_q[1];
    assign m1.rdata = rdata1_q;

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Bench for tqvp_bus_arbiter: vector table of single accesses, scoreboard of
// expected acks, plus arbitration and reset-during-wait sequences.
module tb_tqvp_bus_arbiter;

    localparam int unsigned RT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic        data_ready;
    logic        busy;

    tqvp_bus_arbiter_if m0_if ();
    tqvp_bus_arbiter_if m1_if ();

    tqvp_bus_arbiter #(.READ_TIMEOUT(RT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string ctx    = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", ctx, name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  txn;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          delay;     // strobe cycles before data_ready; -1 = never
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from request edge to ack
        int          exp_strb;  // cycles a strobe is active
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[10];
    logic  exp_last;

    // Peripheral: raises data_ready on the chosen cycle of an active read strobe.
    int ready_delay = -1;
    int rd_cyc      = 0;
    initial begin
        data_ready = 1'b0;
        data_out   = '0;
        forever begin
            @(negedge clk);
            if (data_read_n != 2'b11) begin
                data_ready = (rd_cyc == ready_delay);
                rd_cyc++;
            end else begin
                data_ready = 1'b0;
                rd_cyc     = 0;
            end
        end
    end

    // Scoreboard: every ack must match the oldest expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (m0_if.ack && m1_if.ack) begin
                checks++;
                errors++;
                $display("FAIL %s dual_ack: got both acks expected one", ctx);
            end else if (m0_if.ack || m1_if.ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s unexpected_ack: got ack on port %0d expected none", ctx, m1_if.ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(m1_if.ack), 32'(e.port));
                    chk("rdata", m1_if.ack ? m1_if.rdata : m0_if.rdata, e.rdata);
                    chk("err", 32'(m1_if.ack ? m1_if.err : m0_if.err), 32'(e.err));
                    chk("other_port_quiet",
                        m1_if.ack ? (m0_if.rdata | 32'(m0_if.err)) : (m1_if.rdata | 32'(m1_if.err)),
                        32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic set_fields(input logic port, input logic we, input logic [1:0] txn,
                              input logic [5:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_if.we = we; m1_if.txn = txn; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.we = we; m0_if.txn = txn; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    task automatic set_req(input logic port, input logic v);
        if (port) m1_if.req = v;
        else      m0_if.req = v;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   strb;
        logic got;
        logic [1:0] exp_w;
        logic [1:0] exp_r;
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'h0);
        ready_delay = v.delay;
        data_out    = v.dout;
        set_fields(v.port, v.we, v.txn, v.addr, v.wdata);
        set_req(v.port, 1'b1);
        sb.push_back('{v.port, v.exp_rdata, v.exp_err});
        exp_w = (v.txn != 2'b11 && v.we)  ? v.txn : 2'b11;
        exp_r = (v.txn != 2'b11 && !v.we) ? v.txn : 2'b11;
        cyc = 0; strb = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (data_write_n != 2'b11 || data_read_n != 2'b11) strb++;
            if (cyc == 1) begin
                chk("busy_first", 32'(busy), 32'h1);
                chk("write_n", 32'(data_write_n), 32'(exp_w));
                chk("read_n", 32'(data_read_n), 32'(exp_r));
                if (v.txn != 2'b11) chk("address", 32'(address), 32'(v.addr));
                if (v.txn != 2'b11 && v.we) chk("data_in", data_in, v.wdata);
            end
            if (m0_if.ack || m1_if.ack) begin
                got = 1'b1;
                chk("busy_resp", 32'(busy), 32'h1);
                set_req(v.port, 1'b0);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s ack_timeout: got no ack in %0d cycles expected ack", ctx, cyc);
            set_req(v.port, 1'b0);
        end
        chk("latency", 32'(cyc), 32'(v.exp_lat));
        chk("strobe_cycles", 32'(strb), 32'(v.exp_strb));
        exp_last = v.port;
    endtask

    initial begin
        int   cyc;
        logic got;
        logic ap;
        logic pending;
        logic pend_port;

        m0_if.req = 1'b0; m1_if.req = 1'b0;
        set_fields(1'b0, 1'b0, 2'b00, 6'h00, 32'h0);
        set_fields(1'b1, 1'b0, 2'b00, 6'h00, 32'h0);
        rst_n = 1'b0;

        //             port  we    txn    addr   wdata         dout          dly  rdata         err   lat strb
        vecs[0] = '{1'b0, 1'b1, 2'b10, 6'h05, 32'hDEADBEEF, 32'h00000000, -1, 32'h00000000, 1'b0, 2,  1};
        vecs[1] = '{1'b1, 1'b0, 2'b00, 6'h02, 32'h00000000, 32'h12345678,  0, 32'h00000078, 1'b0, 2,  1};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 6'h10, 32'h00000000, 32'h12345678,  3, 32'h00005678, 1'b0, 5,  4};
        vecs[3] = '{1'b1, 1'b0, 2'b10, 6'h3F, 32'h00000000, 32'hA5A50F0F,  1, 32'hA5A50F0F, 1'b0, 3,  2};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 6'h07, 32'h00000000, 32'hFFFFFFFF, -1, 32'h00000000, 1'b1, 17, 16};
        vecs[5] = '{1'b1, 1'b0, 2'b01, 6'h08, 32'h00000000, 32'hCAFEBABE, 15, 32'h0000BABE, 1'b0, 17, 16};
        vecs[6] = '{1'b0, 1'b1, 2'b11, 6'h09, 32'h11111111, 32'h00000000, -1, 32'h00000000, 1'b1, 1,  0};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 6'h0A, 32'h00000000, 32'h87654321,  0, 32'h00000000, 1'b1, 1,  0};
        vecs[8] = '{1'b1, 1'b1, 2'b00, 6'h21, 32'h000000AA, 32'h00000000, -1, 32'h00000000, 1'b0, 2,  1};
        vecs[9] = '{1'b0, 1'b1, 2'b01, 6'h30, 32'h0000BEEF, 32'h00000000, -1, 32'h00000000, 1'b0, 2,  1};

        ctx = "reset";
        repeat (3) @(negedge clk);
        chk("write_n", 32'(data_write_n), 32'h3);
        chk("read_n", 32'(data_read_n), 32'h3);
        chk("address", 32'(address), 32'h0);
        chk("data_in", data_in, 32'h0);
        chk("busy", 32'(busy), 32'h0);
        chk("acks", 32'({m1_if.ack, m0_if.ack}), 32'h0);
        chk("errs_rdata", m0_if.rdata | m1_if.rdata | 32'({m1_if.err, m0_if.err}), 32'h0);
        rst_n    = 1'b1;
        exp_last = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ctx = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // Reset while a read is stalled in WAIT: strobe drops, no ack follows.
        ctx = "rst_wait";
        @(negedge clk);
        ready_delay = -1;
        set_fields(1'b1, 1'b0, 2'b10, 6'h12, 32'h0);
        set_req(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("read_n_wait", 32'(data_read_n), 32'h2);
        chk("busy_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("read_n", 32'(data_read_n), 32'h3);
        chk("write_n", 32'(data_write_n), 32'h3);
        chk("busy", 32'(busy), 32'h0);
        chk("address", 32'(address), 32'h0);
        chk("ack", 32'({m1_if.ack, m0_if.ack}), 32'h0);
        set_req(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_after", 32'({m1_if.ack, m0_if.ack}), 32'h0);
        end
        exp_last = 1'b1;

        // Both requesters contend; each re-raises req right after its own ack.
        ctx = "rr";
        @(negedge clk);
        set_fields(1'b0, 1'b1, 2'b10, 6'h11, 32'h0000AAAA);
        set_fields(1'b1, 1'b1, 2'b10, 6'h22, 32'h0000BBBB);
        sb.push_back('{~exp_last, 32'h0, 1'b0});
        sb.push_back('{exp_last,  32'h0, 1'b0});
        sb.push_back('{~exp_last, 32'h0, 1'b0});
        sb.push_back('{exp_last,  32'h0, 1'b0});
        set_req(1'b0, 1'b1);
        set_req(1'b1, 1'b1);
        pending = 1'b0; pend_port = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cyc = 0; got = 1'b0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (pending) begin
                    set_req(pend_port, 1'b1);
                    pending = 1'b0;
                end
                if (m0_if.ack || m1_if.ack) begin
                    got = 1'b1;
                    ap  = m1_if.ack;
                    set_req(ap, 1'b0);
                    if (n < 3) begin
                        pending = 1'b1; pend_port = ap;
                    end else begin
                        set_req(~ap, 1'b0);
                    end
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL %s ack_timeout: got no ack for grant %0d expected ack", ctx, n);
                set_req(1'b0, 1'b0);
                set_req(1'b1, 1'b0);
            end
            chk("spacing", 32'(cyc), (n == 0) ? 32'd2 : 32'd3);
        end

        ctx = "end";
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tqvp_bus_arbiter.md
# tqvp_bus_arbiter

Two-port arbiter that shares one TinyQV peripheral register interface (6-bit address, 32-bit data, 2-bit write/read strobes, data_ready) between two requesters, e.g. the SPI register bridge and an on-chip scripted sequencer. It sequences each access through a small FSM, applies round-robin fairness, and masks read data to the transaction width. It also converts a stalled read into an error response after a bounded wait.

## Interface
Parameters:
- READ_TIMEOUT, 16: max cycles a read strobe is held without data_ready before the read is aborted with an error (range 2..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mN_req  in  1  requester N (N=0,1) access request; held with fields stable until mN_ack
- mN_we  in  1  1 = write, 0 = read
- mN_txn  in  2  width: 00 byte, 01 half, 10 word, 11 illegal
- mN_addr  in  6  register address
- mN_wdata  in  32  write data
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  32  read data, valid while mN_ack=1
- mN_err  out  1  error flag, valid while mN_ack=1
- address  out  6  to peripheral
- data_in  out  32  to peripheral
- data_write_n  out  2  write strobe, 11 = idle
- data_read_n  out  2  read strobe, 11 = idle
- data_out  in  32  from peripheral
- data_ready  in  1  read data valid from peripheral
- busy  out  1  FSM not in IDLE

## Operation
- All outputs registered. States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any mN_req is high, grant one. If both are high, grant the port not in last_grant. Latch addr/wdata/txn/we, load address and data_in, and load the strobe: data_write_n=txn for writes, data_read_n=txn for reads. Go to ISSUE.
- Illegal txn=11: no strobe is issued. IDLE goes directly to RESP with err=1, rdata=0.
- ISSUE, write: the strobe is visible for exactly this cycle. data_write_n returns to 11 at the next edge. Go to RESP, err=0.
- ISSUE, read: if data_ready=1, capture the masked data_out, drop data_read_n, and go to RESP. Otherwise go to WAIT with wait counter=1.
- WAIT: data_read_n is held at txn.
  - data_ready=1: capture the masked data_out and go to RESP.
  - Otherwise, if counter+1 == READ_TIMEOUT: go to RESP with err=1, rdata=0.
  - Otherwise: increment the counter.
  - data_read_n returns to 11 on every exit from WAIT.
- Read mask: byte zeroes [31:8]; half zeroes [31:16]; word is unmasked.
- RESP: pulse mN_ack=1 to the granted port only, with mN_rdata/mN_err. Set last_grant to that port and go to IDLE. The non-granted port's ack/rdata/err stay 0.
- After ack, a requester either drops req or presents a new request. A req still high in the following IDLE cycle is treated as a new request.
- address and data_in hold their last values between accesses.

## Timing
- Reset (synchronous, rst_n=0 at a clk edge) drives the following values:
  - data_write_n=11, data_read_n=11, address=0, data_in=0.
  - mN_ack=0, mN_rdata=0, mN_err=0, busy=0.
  - State=IDLE, last_grant=1, so port 0 wins the first tie.
- Reset mid-transaction: the strobes return to 11 at that edge and no ack is issued for the aborted access.
- Write latency: req seen in IDLE at cycle T; strobe at T+1; ack at T+2.
- Read latency: data_ready in the ISSUE cycle gives ack at T+2. Each WAIT cycle adds 1.
- Read strobe is held for at most READ_TIMEOUT cycles (ISSUE cycle included). A timeout gives ack at T+1+READ_TIMEOUT.
- Illegal txn gives ack at T+1.
- Back-to-back: the minimum spacing between peripheral strobes is 3 cycles (ISSUE, RESP, IDLE).
- busy=1 from T+1 through the RESP cycle.

## Test plan
- Reset, then m0 writes word 0xDEADBEEF to addr 0x05 -> one cycle with address=0x05, data_in=0xDEADBEEF, data_write_n=10 at T+1; m0_ack at T+2 with err=0; m1_ack stays 0.
- m1 byte read of addr 0x02; peripheral returns data_out=0x12345678 with data_ready in ISSUE -> data_read_n=00 for 1 cycle; m1_rdata=0x00000078 at T+2.
- Both req high continuously, each dropping and re-raising req after its own ack -> grants alternate 0,1,0,1. Half read by m0 with data_ready 3 cycles after ISSUE -> data_read_n=01 held 4 cycles; m0_rdata=0x00005678.
- Read with data_ready never asserted, READ_TIMEOUT=16 -> data_read_n held 16 cycles then 11; ack at T+17 with err=1, rdata=0.
- m0 requests txn=11 -> no strobe; m0_ack at T+1 with err=1. Separately, rst_n=0 asserted in the WAIT state -> strobes return to 11 next edge, no ack, busy=0.
